centroid_update: RTL

Centroid recompute stage of the k-means accelerator. Accepts a stream of labelled points from the assignment stage and accumulates per-cluster coordinate sums and member counts. At end of stream it divides each sum by its count to produce the new centroid array. That array and a valid pulse feed the convergence-compare stage downstream.

---
 rtl/kmeans_pkg.sv | 23 ++
 rtl/kmeans_serial_div.sv | 67 ++++++
 rtl/centroid_update.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means accelerator: default geometry, centroid
// update FSM states and packed-array indexing helper.
package kmeans_pkg;

  localparam int unsigned K_DEF  = 8;
  localparam int unsigned D_DEF  = 4;
  localparam int unsigned W_DEF  = 8;
  localparam int unsigned CW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DIVIDE,
    ST_DONE
  } state_e;

  // Bit offset of element (k,d) in a flattened K*D*W centroid vector.
  function automatic int unsigned elem_base(input int unsigned k, input int unsigned d,
                                            input int unsigned nd, input int unsigned w);
    return (k * nd + d) * w;
  endfunction

endpackage

// File: rtl/kmeans_serial_div.sv
// Signed-by-unsigned restoring divider: one load cycle, then SW iterations.
// Quotient truncates toward zero; done_c/quot_c are valid on the last iteration.
module kmeans_serial_div #(
  parameter int unsigned SW = 24,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic signed [SW-1:0] dividend,
  input  logic [CW-1:0]        divisor,
  output logic                 busy_c,
  output logic                 done_c,
  output logic [SW-1:0]        quot_c
);
  localparam int unsigned NW = $clog2(SW + 1);

  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [SW-1:0] mag_q, mag_d;
  logic [CW-1:0] div_q, div_d;
  logic          neg_q, neg_d;
  logic [CW:0]   shifted;
  logic          ge;

  // Magnitude is divided; sign of the dividend is reapplied to the quotient.
  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mag_d   = mag_q;
    div_d   = div_q;
    neg_d   = neg_q;
    shifted = {rem_q, mag_q[SW-1]};
    ge      = shifted >= {1'b0, div_q};
    if (load) begin
      neg_d = dividend[SW-1];
      mag_d = dividend[SW-1] ? SW'(-dividend) : SW'(dividend);
      rem_d = '0;
      div_d = divisor;
      cnt_d = NW'(SW);
    end else if (cnt_q != '0) begin
      rem_d = ge ? CW'(shifted - {1'b0, div_q}) : CW'(shifted);
      mag_d = {mag_q[SW-2:0], ge};
      cnt_d = cnt_q - NW'(1);
    end
    busy_c = cnt_q != '0;
    done_c = cnt_q == NW'(1);
    quot_c = neg_q ? SW'(-mag_d) : mag_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      mag_q <= '0;
      div_q <= '0;
      neg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      mag_q <= mag_d;
      div_q <= div_d;
      neg_q <= neg_d;
    end
  end

endmodule

// File: rtl/centroid_update.sv
// Centroid recompute stage: accumulates labelled points per cluster, then
// serially divides each sum by its member count to form the new centroids.
module centroid_update
  import kmeans_pkg::*;
#(
  parameter int unsigned K  = K_DEF,
  parameter int unsigned D  = D_DEF,
  parameter int unsigned W  = W_DEF,
  parameter int unsigned CW = CW_DEF,
  localparam int unsigned SW = W + CW,
  localparam int unsigned LW = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [K*D*W-1:0] old_c,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [D*W-1:0]   pt_data,
  input  logic [LW-1:0]    pt_label,
  input  logic             pt_last,
  output logic [K*D*W-1:0] new_c,
  output logic             c_valid,
  output logic             busy,
  output logic             err
);
  localparam int unsigned NE = K * D;
  localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        e_q, e_d;
  logic signed [SW-1:0] sum_q [NE];
  logic signed [SW-1:0] sum_d [NE];
  logic [CW-1:0]        cnt_q [K];
  logic [CW-1:0]        cnt_d [K];
  logic [W-1:0]         res_q [NE];
  logic [W-1:0]         res_d [NE];
  logic [K*D*W-1:0]     new_c_q, new_c_d;
  logic err_q, err_d, pt_ready_q, pt_ready_d, busy_q, busy_d, c_valid_q, c_valid_d;

  logic                 div_load, div_busy_c, div_done_c;
  logic [SW-1:0]        div_quot_c;
  logic signed [SW-1:0] div_num;
  logic [CW-1:0]        div_den;
  int unsigned          ek, ed;
  logic signed [W-1:0]  pd;

  always_comb begin
    ek      = 32'(e_q) / D;
    ed      = 32'(e_q) % D;
    div_num = sum_q[e_q];
    div_den = cnt_q[LW'(ek)];
  end

  kmeans_serial_div #(.SW(SW), .CW(CW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .dividend (div_num),
    .divisor  (div_den),
    .busy_c   (div_busy_c),
    .done_c   (div_done_c),
    .quot_c   (div_quot_c)
  );

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    err_d    = err_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    new_c_d  = new_c_q;
    div_load = 1'b0;
    pd       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          err_d   = 1'b0;
          e_d     = '0;
          for (int i = 0; i < int'(NE); i++) sum_d[i] = '0;
          for (int k = 0; k < int'(K); k++) cnt_d[k] = '0;
        end
      end
      ST_ACCUM: begin
        if (pt_valid && pt_ready_q) begin
          // Out-of-range labels and saturated clusters drop the point.
          if (32'(pt_label) >= K) begin
            err_d = 1'b1;
          end else if (cnt_q[pt_label] == '1) begin
            err_d = 1'b1;
          end else begin
            cnt_d[pt_label] = cnt_q[pt_label] + CW'(1);
            for (int d = 0; d < int'(D); d++) begin
              pd = pt_data[d*W +: W];
              sum_d[IW'(32'(pt_label) * D + 32'(d))] =
                sum_q[IW'(32'(pt_label) * D + 32'(d))] + SW'(pd);
            end
          end
          if (pt_last) state_d = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        div_load = !div_busy_c;
        if (div_done_c) begin
          // Empty clusters keep their previous centroid.
          res_d[e_q] = (cnt_q[LW'(ek)] == '0) ? old_c[elem_base(ek, ed, D, W) +: W]
                                              : div_quot_c[W-1:0];
          if (32'(e_q) == NE - 1) state_d = ST_DONE;
          else                    e_d = e_q + IW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_q == ST_DIVIDE && state_d == ST_DONE) begin
      for (int i = 0; i < int'(NE); i++) new_c_d[i*W +: W] = res_d[i];
    end
    pt_ready_d = state_d == ST_ACCUM;
    busy_d     = state_d != ST_IDLE;
    c_valid_d  = state_d == ST_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      e_q        <= '0;
      err_q      <= 1'b0;
      new_c_q    <= '0;
      pt_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      c_valid_q  <= 1'b0;
      for (int i = 0; i < int'(NE); i++) begin
        sum_q[i] <= '0;
        res_q[i] <= '0;
      end
      for (int k = 0; k < int'(K); k++) cnt_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      err_q      <= err_d;
      new_c_q    <= new_c_d;
      pt_ready_q <= pt_ready_d;
      busy_q     <= busy_d;
      c_valid_q  <= c_valid_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
    end
  end

  assign pt_ready = pt_ready_q;
  assign busy     = busy_q;
  assign c_valid  = c_valid_q;
  assign err      = err_q;
  assign new_c    = new_c_q;

endmodule
